// File: rtl/buffer_op_scheduler_if.sv
// buffer_op_scheduler_if: requester/copy-unit signals shared by the scheduler and its environment.
interface buffer_op_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int BUF_W = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ*BUF_W-1:0] req_src;
    logic [NREQ*BUF_W-1:0] req_dst;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  done_err;
    logic                  start_op;
    logic [BUF_W-1:0]      op_src;
    logic [BUF_W-1:0]      op_dst;
    logic                  unit_working;
    logic                  err_sticky;
    logic                  err_clr;
    modport master (
        output req, req_src, req_dst, unit_working, err_clr,
        input  grant, done, done_err, start_op, op_src, op_dst, err_sticky
    );
    modport slave (
        input  req, req_src, req_dst, unit_working, err_clr,
        output grant, done, done_err, start_op, op_src, op_dst, err_sticky
    );
endinterface

// File: rtl/buffer_op_scheduler.sv
// buffer_op_scheduler: round-robin arbiter that issues one buffer copy at a time and
// supervises the copy unit with an arm timeout and a run watchdog.
module buffer_op_scheduler #(
    parameter int NREQ    = 4,
    parameter int BUF_W   = 3,
    parameter int WD_W    = 12,
    parameter int ARM_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    buffer_op_scheduler_if.slave   bus
);
    localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int AW  = $clog2(ARM_MAX + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, ARM, RUN, DONE, ERR} state_t;
    state_t           state_q;
    logic [IDW-1:0]   id_q, lw_q, pick;
    logic             any;
    logic [AW-1:0]    arm_q;
    logic [WD_W-1:0]  wd_q;
    logic [NREQ-1:0]  grant_q, done_q;
    logic             done_err_q, start_q, err_q;
    logic [BUF_W-1:0] src_q, dst_q;
    // Scan downwards so the requester closest after last winner is the final assignment.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(lw_q) + k) % NREQ]) begin
                pick = IDW'((int'(lw_q) + k) % NREQ);
                any  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            id_q       <= '0;
            lw_q       <= IDW'(NREQ - 1);
            arm_q      <= '0;
            wd_q       <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            done_err_q <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
        end else begin
            start_q    <= 1'b0;
            done_q     <= '0;
            done_err_q <= 1'b0;
            if (bus.err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: if (any && !bus.unit_working) begin
                    id_q    <= pick;
                    src_q   <= bus.req_src[int'(pick)*BUF_W +: BUF_W];
                    dst_q   <= bus.req_dst[int'(pick)*BUF_W +: BUF_W];
                    grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    start_q <= 1'b1;
                    arm_q   <= '0;
                    wd_q    <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: state_q <= ARM;
                ARM: if (bus.unit_working) state_q <= RUN;
                else if (arm_q == AW'(ARM_MAX - 1)) begin
                    state_q    <= ERR;
                    done_q     <= grant_q;
                    done_err_q <= 1'b1;
                    err_q      <= 1'b1;
                end else arm_q <= arm_q + 1'b1;
                RUN: if (!bus.unit_working) begin
                    state_q <= DONE;
                    done_q  <= grant_q;
                end else if (wd_q == {WD_W{1'b1}} - 1'b1) begin
                    state_q    <= ERR;
                    done_q     <= grant_q;
                    done_err_q <= 1'b1;
                    err_q      <= 1'b1;
                end else wd_q <= wd_q + 1'b1;
                DONE, ERR: begin
                    lw_q    <= id_q;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.done_err   = done_err_q;
    assign bus.start_op   = start_q;
    assign bus.op_src     = src_q;
    assign bus.op_dst     = dst_q;
    assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_buffer_op_scheduler.sv
// tb_buffer_op_scheduler: directed scenarios with a done-pulse scoreboard for buffer_op_scheduler.
module tb_buffer_op_scheduler;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    typedef struct {
        logic [3:0] d;
        logic       e;
    } exp_t;
    exp_t exp_q[$];
    buffer_op_scheduler_if #(.NREQ(4), .BUF_W(3)) bus ();
    buffer_op_scheduler #(.NREQ(4), .BUF_W(3), .WD_W(12), .ARM_MAX(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rstn && bus.done != 4'b0) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_done: observed %0h expected none", bus.done);
            end
            if (exp_q.size() != 0) begin
                exp_t x;
                x = exp_q.pop_front();
                n_cmp++;
                assert (bus.done === x.d && bus.done_err === x.e) else begin
                    n_bad++;
                    $error("FAIL done_sb: observed %0h/%0b expected %0h/%0b", bus.done, bus.done_err, x.d, x.e);
                end
            end
        end
    end
    task automatic wait_start(output int s);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = bus.start_op;
        end
        check("start_seen", 32'(seen), 1);
        s = cyc;
    endtask
    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            seen = |bus.done;
        end
        check("done_seen", 32'(seen), 1);
    endtask
    task automatic push(input int id, input bit err);
        exp_t x;
        x.d = 4'(1 << id);
        x.e = err;
        exp_q.push_back(x);
    endtask
    // len = cycles of unit_working starting two cycles after start_op; 0 means never.
    task automatic do_op(input int id, input int len, input bit err);
        int s;
        push(id, err);
        wait_start(s);
        check("grant", bus.grant, 32'(1 << id));
        check("op_src", bus.op_src, 32'((id + 2) % 8));
        check("op_dst", bus.op_dst, 32'((id + 5) % 8));
        @(posedge clk); #1;
        check("start_one_cycle", bus.start_op, 0);
        if (len > 0) begin
            @(posedge clk); #1;
            bus.unit_working = 1'b1;
            repeat (len) @(posedge clk);
            #1 bus.unit_working = 1'b0;
        end
        wait_done(100);
        check("latency", cyc - s, err ? 9 : len + 3);
        check("op_src_hold", bus.op_src, 32'((id + 2) % 8));
        check("op_dst_hold", bus.op_dst, 32'((id + 5) % 8));
    endtask
    initial begin
        int s;
        bit ok;
        bus.req = '0;
        bus.unit_working = 1'b0;
        bus.err_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_src[i*3 +: 3] = 3'((i + 2) % 8);
            bus.req_dst[i*3 +: 3] = 3'((i + 5) % 8);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_done_err", bus.done_err, 0);
        check("rst_start", bus.start_op, 0);
        check("rst_src", bus.op_src, 0);
        check("rst_dst", bus.op_dst, 0);
        check("rst_err", bus.err_sticky, 0);
        rstn = 1'b1;
        // Single long operation
        @(negedge clk);
        bus.req = 4'b0001;
        do_op(0, 1024, 1'b0);
        bus.req = 4'b0000;
        check("single_err", bus.err_sticky, 0);
        // Fairness from a fresh reset
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) do_op(k % 4, 3, 1'b0);
        bus.req = 4'b0000;
        // Arm timeout with err_clr held: set must win
        bus.req = 4'b0100;
        bus.err_clr = 1'b1;
        do_op(2, 0, 1'b1);
        bus.req = 4'b0000;
        check("err_set_wins", bus.err_sticky, 1);
        bus.err_clr = 1'b0;
        @(negedge clk);
        check("err_sticky_hold", bus.err_sticky, 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_cleared", bus.err_sticky, 0);
        // Watchdog: working stuck high, pending requester waits for it to fall
        bus.req = 4'b1001;
        push(3, 1'b1);
        wait_start(s);
        check("wd_grant", bus.grant, 4'b1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.unit_working = 1'b1;
        wait_done(5000);
        check("wd_latency", cyc - s, 4098);
        check("wd_err_sticky", bus.err_sticky, 1);
        bus.req = 4'b0001;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.start_op || bus.grant != 4'b0) ok = 1'b0;
        end
        check("wd_blocked", 32'(ok), 1);
        @(posedge clk); #1;
        bus.unit_working = 1'b0;
        do_op(0, 3, 1'b0);
        bus.req = 4'b0000;
        // Reset in the middle of RUN
        bus.req = 4'b0010;
        wait_start(s);
        check("rr_grant", bus.grant, 4'b0010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.unit_working = 1'b1;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_grant", bus.grant, 0);
        check("arst_done", bus.done, 0);
        check("arst_start", bus.start_op, 0);
        check("arst_src", bus.op_src, 0);
        check("arst_dst", bus.op_dst, 0);
        check("arst_err", bus.err_sticky, 0);
        bus.unit_working = 1'b0;
        bus.req = 4'b0100;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        do_op(2, 3, 1'b0);
        bus.req = 4'b0000;
        // Withdrawn request during another operation
        bus.req = 4'b0001;
        fork
            do_op(0, 10, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 bus.req[1] = 1'b1;
                @(posedge clk);
                #1 bus.req[1] = 1'b0;
            end
        join
        bus.req = 4'b0000;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.start_op || bus.grant != 4'b0) ok = 1'b0;
        end
        check("withdraw_idle", 32'(ok), 1);
        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/buffer_op_scheduler.md
BUFFER_OP_SCHEDULER -- requirements
Module: buffer_op_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the buffer-copy unit.
REQ-002 SHALL have parameter BUF_W, default 3, width of source/destination buffer-select fields.
REQ-003 SHALL have parameter WD_W, default 12, width of the RUN-phase watchdog counter.
REQ-004 SHALL have parameter ARM_MAX, default 8, maximum cycles from start to copy-unit working.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 req  input  NREQ  per-requester request level.
REQ-008 req_src  input  NREQ*BUF_W  per-requester source buffer select; slice i belongs to requester i.
REQ-009 req_dst  input  NREQ*BUF_W  per-requester destination buffer select.
REQ-010 grant  output  NREQ  one-hot; high for the granted requester from ISSUE through DONE/ERR.
REQ-011 done  output  NREQ  one-hot, single-cycle completion pulse.
REQ-012 done_err  output  1  high with done when the operation ended in error.
REQ-013 start_op  output  1  single-cycle start pulse to the copy unit.
REQ-014 op_src, op_dst  output  BUF_W each  latched selects, stable from ISSUE until return to IDLE.
REQ-015 unit_working  input  1  busy level from the copy unit.
REQ-016 err_sticky  output  1  set on any error; cleared by err_clr or reset.
REQ-017 err_clr  input  1  synchronous clear of err_sticky.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, ARM, RUN, DONE, ERR.
REQ-019 IDLE: if any req bit is high, SHALL select winner round-robin, starting at (last_winner+1) mod NREQ, latch its id/src/dst, go to ISSUE; else stay.
REQ-020 ISSUE: start_op=1 for exactly this cycle; next state ARM.
REQ-021 ARM: unit_working=1 -> RUN; ARM_MAX cycles in ARM without working -> ERR.
REQ-022 RUN: unit_working=0 -> DONE; watchdog counting 2^WD_W-1 cycles in RUN -> ERR.
REQ-023 DONE: done[id]=1, done_err=0 for one cycle; last_winner<=id; next IDLE.
REQ-024 ERR: done[id]=1, done_err=1 for one cycle; err_sticky<=1; last_winner<=id; next IDLE.
REQ-025 No grant SHALL be issued in the DONE/ERR cycle; minimum spacing between start_op pulses is 4 cycles.
REQ-026 Requester SHALL hold req until its done; req values change after grant SHALL be ignored.
REQ-027 Requester dropping req before grant SHALL simply not be selected; no done for it.
REQ-028 unit_working high while IDLE SHALL block arbitration until it falls.
REQ-029 err_clr and a simultaneous error SHALL leave err_sticky=1 (set wins).
REQ-030 After reset last_winner SHALL be NREQ-1, so requester 0 has first priority.
REQ-031 ARM and watchdog counters SHALL reset to 0 on entry to ISSUE.

Reset
REQ-032 rstn low SHALL immediately force state IDLE, grant=0, done=0, done_err=0, start_op=0, op_src=op_dst=0, err_sticky=0, counters=0, last_winner=NREQ-1.
REQ-033 Reset mid-operation SHALL abandon it with no done pulse; first grant after release follows REQ-030/REQ-028.

Verification
REQ-034 Single op: req=0001, src=2, dst=5, unit_working high cycles 2..1025 after start -> one start_op, op_src=2/op_dst=5 stable, done=0001 with done_err=0 one cycle after working falls.
REQ-035 Fairness: req=1111 held, 8 ops -> grant order 0,1,2,3,0,1,2,3; each done pulses once per op.
REQ-036 ARM timeout: unit_working never rises -> ERR after 8 ARM cycles, done with done_err=1, err_sticky=1; err_clr pulse -> err_sticky=0.
REQ-037 Watchdog: working stuck high -> ERR after 4095 RUN cycles; next pending requester then granted only after working falls.
REQ-038 Reset in RUN: assert rstn low -> all outputs 0 asynchronously, no done; after release req=0100 -> grant=0100.
REQ-039 Withdraw: req[1] pulses high 1 cycle during another op, then low -> requester 1 never granted, no done[1].
